countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_if.sv | 31 +++
 rtl/countdown_timer.sv | 112 +++++++++++
 tb/tb_countdown_timer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Command, preset and status signals of the MM:SS countdown timer.
// The slave modport is the timer side; the master modport is the controller side.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic       start;
  logic       pause;
  logic [2:0] pre_min_t;
  logic [3:0] pre_min_u;
  logic [2:0] pre_sec_t;
  logic [3:0] pre_sec_u;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic       running;
  logic       expired;
  logic       done;

  modport slave (
    input  tick, load, start, pause,
    input  pre_min_t, pre_min_u, pre_sec_t, pre_sec_u,
    output min_t, min_u, sec_t, sec_u, running, expired, done
  );

  modport master (
    output tick, load, start, pause,
    output pre_min_t, pre_min_u, pre_sec_t, pre_sec_u,
    input  min_t, min_u, sec_t, sec_u, running, expired, done
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer (00:00-59:59) with load/start/pause commands and a done pulse.
// Commands take effect on the next rising edge; all outputs are registered, with no backpressure.
module countdown_timer (
  input  logic              i_clk1,
  input  logic              i_clr_n,
  countdown_timer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_min_t, w_min_t_nxt, w_dec_min_t, w_cl_min_t;
  logic [3:0] r_min_u, w_min_u_nxt, w_dec_min_u, w_cl_min_u;
  logic [2:0] r_sec_t, w_sec_t_nxt, w_dec_sec_t, w_cl_sec_t;
  logic [3:0] r_sec_u, w_sec_u_nxt, w_dec_sec_u, w_cl_sec_u;
  logic       r_done, w_done_nxt;
  logic       r_running, r_expired;
  logic       w_is_zero, w_is_one;

  assign w_cl_min_t = (bus.pre_min_t > 3'd5) ? 3'd5 : bus.pre_min_t;
  assign w_cl_min_u = (bus.pre_min_u > 4'd9) ? 4'd9 : bus.pre_min_u;
  assign w_cl_sec_t = (bus.pre_sec_t > 3'd5) ? 3'd5 : bus.pre_sec_t;
  assign w_cl_sec_u = (bus.pre_sec_u > 4'd9) ? 4'd9 : bus.pre_sec_u;

  assign w_is_zero = (r_min_t == 3'd0) && (r_min_u == 4'd0) &&
                     (r_sec_t == 3'd0) && (r_sec_u == 4'd0);
  assign w_is_one  = (r_min_t == 3'd0) && (r_min_u == 4'd0) &&
                     (r_sec_t == 3'd0) && (r_sec_u == 4'd1);

  // One-second decrement with digit borrows; never evaluated at 00:00 since RUN always holds a nonzero count
  always_comb begin
    w_dec_min_t = r_min_t;
    w_dec_min_u = r_min_u;
    w_dec_sec_t = r_sec_t;
    w_dec_sec_u = r_sec_u;
    if (r_sec_u != 4'd0) begin
      w_dec_sec_u = r_sec_u - 4'd1;
    end else begin
      w_dec_sec_u = 4'd9;
      if (r_sec_t != 3'd0) begin
        w_dec_sec_t = r_sec_t - 3'd1;
      end else begin
        w_dec_sec_t = 3'd5;
        if (r_min_u != 4'd0) begin
          w_dec_min_u = r_min_u - 4'd1;
        end else begin
          w_dec_min_u = 4'd9;
          w_dec_min_t = r_min_t - 3'd1;
        end
      end
    end
  end

  // Only the highest-priority asserted command is acted on: load > pause > start > tick
  always_comb begin
    w_state_nxt = r_state;
    w_min_t_nxt = r_min_t;
    w_min_u_nxt = r_min_u;
    w_sec_t_nxt = r_sec_t;
    w_sec_u_nxt = r_sec_u;
    w_done_nxt  = 1'b0;
    if (bus.load) begin
      w_min_t_nxt = w_cl_min_t;
      w_min_u_nxt = w_cl_min_u;
      w_sec_t_nxt = w_cl_sec_t;
      w_sec_u_nxt = w_cl_sec_u;
      w_state_nxt = S_IDLE;
    end else if (bus.pause) begin
      if (r_state == S_RUN) w_state_nxt = S_PAUSED;
    end else if (bus.start) begin
      if ((r_state == S_IDLE && !w_is_zero) || r_state == S_PAUSED) w_state_nxt = S_RUN;
    end else if (bus.tick && r_state == S_RUN) begin
      w_min_t_nxt = w_dec_min_t;
      w_min_u_nxt = w_dec_min_u;
      w_sec_t_nxt = w_dec_sec_t;
      w_sec_u_nxt = w_dec_sec_u;
      if (w_is_one) begin
        w_state_nxt = S_EXPIRED;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk1 or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state   <= S_IDLE;
      r_min_t   <= 3'd0;
      r_min_u   <= 4'd0;
      r_sec_t   <= 3'd0;
      r_sec_u   <= 4'd0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_min_t   <= w_min_t_nxt;
      r_min_u   <= w_min_u_nxt;
      r_sec_t   <= w_sec_t_nxt;
      r_sec_u   <= w_sec_u_nxt;
      r_done    <= w_done_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_expired <= (w_state_nxt == S_EXPIRED);
    end
  end

  assign bus.min_t   = r_min_t;
  assign bus.min_u   = r_min_u;
  assign bus.sec_t   = r_sec_t;
  assign bus.sec_u   = r_sec_u;
  assign bus.running = r_running;
  assign bus.expired = r_expired;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios with literal expectations plus a random run
// compared every cycle against a seconds-based model of the timer.
module tb_countdown_timer;
  logic clk1  = 1'b0;
  logic clr_n = 1'b0;

  countdown_timer_if bus();

  countdown_timer dut (
    .i_clk1 (clk1),
    .i_clr_n(clr_n),
    .bus    (bus)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
  int m_st  = M_IDLE;
  int m_cnt = 0;
  bit m_done = 1'b0;

  function automatic int preset_secs(logic [2:0] mt, logic [3:0] mu, logic [2:0] st, logic [3:0] su);
    int a, b, c, d;
    a = (mt > 3'd5) ? 5 : int'(mt);
    b = (mu > 4'd9) ? 9 : int'(mu);
    c = (st > 3'd5) ? 5 : int'(st);
    d = (su > 4'd9) ? 9 : int'(su);
    return a * 600 + b * 60 + c * 10 + d;
  endfunction

  // Remaining time kept as plain seconds; digits are derived only when comparing
  always @(posedge clk1 or negedge clr_n) begin
    if (!clr_n) begin
      m_st = M_IDLE; m_cnt = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (bus.load) begin
        m_cnt = preset_secs(bus.pre_min_t, bus.pre_min_u, bus.pre_sec_t, bus.pre_sec_u);
        m_st  = M_IDLE;
      end else if (bus.pause) begin
        if (m_st == M_RUN) m_st = M_PAUSED;
      end else if (bus.start) begin
        if (m_st == M_PAUSED || (m_st == M_IDLE && m_cnt > 0)) m_st = M_RUN;
      end else if (bus.tick && m_st == M_RUN) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_st = M_EXP; m_done = 1'b1;
        end
      end
    end
  end

  function automatic logic [16:0] model_vec();
    int c;
    c = m_cnt;
    return {3'(c / 600), 4'((c / 60) % 10), 3'((c % 60) / 10), 4'(c % 10),
            (m_st == M_RUN), (m_st == M_EXP), m_done};
  endfunction

  logic [16:0] dut_vec;
  assign dut_vec = {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u, bus.running, bus.expired, bus.done};

  always @(negedge clk1) begin
    if (chk_en) begin
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t dut=%h model=%h", $time, dut_vec, model_vec());
      end
    end
  end

  task automatic chk_lit(string nm, int mt, int mu, int st, int su, bit run, bit ex);
    logic [15:0] got, want;
    got  = {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u, bus.running, bus.expired};
    want = {3'(mt), 4'(mu), 3'(st), 4'(su), run, ex};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chk_done(string nm, bit want);
    n_checks++;
    if (bus.done !== want) begin
      n_fail++;
      $display("FAIL %s done got=%b want=%b", nm, bus.done, want);
    end
  endtask

  task automatic set_pre(int mt, int mu, int st, int su);
    bus.pre_min_t = 3'(mt);
    bus.pre_min_u = 4'(mu);
    bus.pre_sec_t = 3'(st);
    bus.pre_sec_u = 4'(su);
  endtask

  task automatic cyc(bit l, bit s, bit p, bit t);
    bus.load = l; bus.start = s; bus.pause = p; bus.tick = t;
    @(negedge clk1);
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
  endtask

  initial begin
    bit l, s, p, t;
    int r;
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
    set_pre(0, 0, 0, 0);
    @(negedge clk1);
    bus.load = 1'b1; bus.start = 1'b1; bus.tick = 1'b1;
    @(negedge clk1);
    chk_lit("reset_state", 0, 0, 0, 0, 0, 0);
    chk_done("reset_done", 1'b0);
    bus.load = 1'b0; bus.start = 1'b0; bus.tick = 1'b0;
    clr_n  = 1'b1;
    chk_en = 1'b1;
    cyc(0, 1, 0, 0);
    chk_lit("post_reset_start", 0, 0, 0, 0, 0, 0);

    set_pre(0, 1, 0, 0); cyc(1, 0, 0, 0); chk_lit("m1_load", 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0); chk_lit("m1_start", 0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1); chk_lit("m1_tick1", 0, 0, 5, 9, 1, 0);
    repeat (58) cyc(0, 0, 0, 1);
    chk_lit("m1_tick59", 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1); chk_lit("m1_tick60", 0, 0, 0, 0, 0, 1); chk_done("m1_done_hi", 1'b1);
    cyc(0, 0, 0, 0); chk_done("m1_done_lo", 1'b0); chk_lit("m1_hold", 0, 0, 0, 0, 0, 1);

    cyc(0, 1, 0, 1); chk_lit("exp_start_tick", 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1); chk_lit("exp_pause_tick", 0, 0, 0, 0, 0, 1);
    set_pre(0, 0, 0, 2); cyc(1, 0, 0, 0); chk_lit("exp_load", 0, 0, 0, 2, 0, 0);

    set_pre(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1); chk_lit("borrow_chain", 0, 9, 5, 9, 1, 0);

    set_pre(0, 0, 0, 5); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); chk_lit("p_two_ticks", 0, 0, 0, 3, 1, 0);
    cyc(0, 0, 1, 1); chk_lit("p_pause_tick", 0, 0, 0, 3, 0, 0);
    repeat (3) cyc(0, 0, 0, 1);
    chk_lit("p_hold", 0, 0, 0, 3, 0, 0);
    cyc(0, 1, 0, 0); chk_lit("p_resume", 0, 0, 0, 3, 1, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk_lit("p_expired", 0, 0, 0, 0, 0, 1); chk_done("p_done", 1'b1);

    set_pre(7, 15, 7, 12); cyc(1, 0, 0, 0); chk_lit("clamp", 5, 9, 5, 9, 0, 0);
    set_pre(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    chk_lit("zero_start", 0, 0, 0, 0, 0, 0);

    set_pre(0, 3, 3, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 1);
    chk_lit("rst_pre", 0, 3, 2, 7, 1, 0);
    #2 clr_n = 1'b0;
    #1 chk_lit("rst_async", 0, 0, 0, 0, 0, 0);
    @(negedge clk1);
    clr_n = 1'b1;
    cyc(0, 1, 0, 0); chk_lit("rst_idle", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1); chk_lit("rst_no_count", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      l = 1'b0; s = 1'b0; p = 1'b0; t = 1'b0;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        set_pre(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        l = 1'b1; t = 1'($urandom_range(0, 1));
      end else if (r < 9) begin
        p = 1'b1; t = 1'($urandom_range(0, 1));
      end else if (r < 17) begin
        s = 1'b1;
      end else if (r < 60) begin
        t = 1'b1;
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 clr_n = 1'b0;
        @(negedge clk1);
        clr_n = 1'b1;
      end else begin
        cyc(l, s, p, t);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
